// File: rtl/hex_disp_pkg.sv
// ---------------------------------------------------------------------------
// hex_disp_pkg
// Shared types and constants for the HEX0..HEX5 scrolling-message path.
//   scroll_state_t : controller state (IDLE, SCROLL)
//   NIBBLE_ZERO    : nibble shifted into HEX0 once the message is exhausted
//   SEG_BLANK      : all-segments-off pattern used by the top-level blank mux
// ---------------------------------------------------------------------------
package hex_disp_pkg;

    typedef enum logic {IDLE, SCROLL} scroll_state_t;

    localparam logic [3:0] NIBBLE_ZERO = 4'h0;
    localparam logic [6:0] SEG_BLANK   = 7'b1111111;

endpackage

// File: rtl/hex_scroll_ctrl_if.sv
// ---------------------------------------------------------------------------
// hex_scroll_ctrl_if
// Message handshake and display-side signals of hex_scroll_ctrl.
//   msg_valid / msg_data / msg_ready : message offer and acceptance
//   stop                             : abort an active scroll
//   digit / blank                    : per-display nibble and dark flag
//   busy / done                      : scroll status, completion pulse
// master = message source, slave = scroll controller.
// ---------------------------------------------------------------------------
interface hex_scroll_ctrl_if #(
    parameter int NUM_DIGITS  = 6,
    parameter int MSG_NIBBLES = 8
);
    logic                     msg_valid;
    logic [4*MSG_NIBBLES-1:0] msg_data;
    logic                     msg_ready;
    logic                     stop;
    logic [4*NUM_DIGITS-1:0]  digit;
    logic [NUM_DIGITS-1:0]    blank;
    logic                     busy;
    logic                     done;

    modport master (
        output msg_valid, msg_data, stop,
        input  msg_ready, digit, blank, busy, done
    );

    modport slave (
        input  msg_valid, msg_data, stop,
        output msg_ready, digit, blank, busy, done
    );
endinterface

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Divides clk down to a one-cycle tick every TICK_DIV cycles while enabled.
//   clk   : system clock
//   reset : synchronous, active-high
//   en    : count enable; count is held at 0 when low
//   clr   : clears the count, takes priority over en
//   tick  : high on the cycle the count sits at TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset || clr || !en) begin
            r_count <= '0;
        end else if (w_at_max) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Suppressed on a clearing edge so an abort never coincides with a step.
    assign tick = en && !clr && w_at_max;
endmodule

// File: rtl/hex_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// hex_scroll_ctrl
// Scrolls a multi-nibble message right-to-left across the hex displays, one
// digit per divided tick, and pulses done once the window has fully cleared.
//   clk   : system clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : hex_scroll_ctrl_if.slave (message handshake, stop, display, status)
//
// state  | meaning
// IDLE   | display dark, msg_ready high, waiting for a message
// SCROLL | shifting the window once per tick until all digits are blank again
// ---------------------------------------------------------------------------
module hex_scroll_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int MSG_NIBBLES = 8,
    parameter int TICK_DIV    = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    hex_scroll_ctrl_if.slave bus
);
    localparam int TOTAL_STEPS = MSG_NIBBLES + NUM_DIGITS;
    localparam int STEP_W      = $clog2(TOTAL_STEPS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TOTAL_STEPS - 1);
    localparam logic [STEP_W-1:0] MSG_STEPS = STEP_W'(MSG_NIBBLES);

    scroll_state_t            r_state;
    scroll_state_t            w_state_next;
    logic [4*MSG_NIBBLES-1:0] r_msg;
    logic [4*NUM_DIGITS-1:0]  r_digit;
    logic [NUM_DIGITS-1:0]    r_blank;
    logic [STEP_W-1:0]        r_step;
    logic                     r_done;

    logic w_accept;
    logic w_abort;
    logic w_tick_en;
    logic w_tick;
    logic w_last;
    logic w_ready;
    logic w_busy;

    assign w_accept  = (r_state == IDLE) && bus.msg_valid;
    assign w_abort   = (r_state == SCROLL) && bus.stop;
    assign w_tick_en = (r_state == SCROLL);
    // r_step counts steps already taken, so LAST_STEP here means this tick
    // performs the final step.
    assign w_last    = w_tick && (r_step == LAST_STEP);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (w_tick_en),
        .clr   (w_abort),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (w_accept) w_state_next = SCROLL;
            end
            SCROLL: begin
                w_busy = 1'b1;
                if (w_abort || w_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_msg   <= '0;
            r_digit <= '0;
            r_blank <= '1;
            r_step  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_last;
            if (w_accept) begin
                r_msg   <= bus.msg_data;
                r_digit <= '0;
                r_blank <= '1;
                r_step  <= '0;
            end else if (w_abort) begin
                r_digit <= '0;
                r_blank <= '1;
                r_step  <= '0;
            end else if (w_tick) begin
                r_step <= r_step + 1'b1;
                if (r_step < MSG_STEPS) begin
                    // Message register shifts out MSB-first into HEX0.
                    r_digit <= {r_digit[4*NUM_DIGITS-5:0], r_msg[4*MSG_NIBBLES-1 -: 4]};
                    r_blank <= {r_blank[NUM_DIGITS-2:0], 1'b0};
                    r_msg   <= {r_msg[4*MSG_NIBBLES-5:0], NIBBLE_ZERO};
                end else begin
                    r_digit <= {r_digit[4*NUM_DIGITS-5:0], NIBBLE_ZERO};
                    r_blank <= {r_blank[NUM_DIGITS-2:0], 1'b1};
                end
            end
        end
    end

    assign bus.msg_ready = w_ready;
    assign bus.busy      = w_busy;
    assign bus.digit     = r_digit;
    assign bus.blank     = r_blank;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_scroll_ctrl
// Two instances: TICK_DIV=4 (bus4) and TICK_DIV=1 (bus1), both 6 digits and
// 8 nibbles. Stimulus pushes the expected display snapshots into a queue per
// instance; a monitor per instance pops one entry whenever the visible
// outputs change and compares cycle, digit, blank, busy, done and msg_ready.
// Cycle n is the value of cyc after posedge n; a message driven while cyc=c
// is accepted on edge c+1 and step k appears on edge accept+TICK_DIV*k.
// ---------------------------------------------------------------------------
module tb_hex_scroll_ctrl;

    typedef struct {
        int          cyc;
        logic [23:0] dig;
        logic [5:0]  blk;
        logic        busy;
        logic        done;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    exp_t        q4[$];
    exp_t        q1[$];
    exp_t        e4, e1;
    logic [31:0] prev4, prev1, cur4, cur1;

    hex_scroll_ctrl_if #(.NUM_DIGITS(6), .MSG_NIBBLES(8)) bus4 ();
    hex_scroll_ctrl_if #(.NUM_DIGITS(6), .MSG_NIBBLES(8)) bus1 ();

    hex_scroll_ctrl #(.NUM_DIGITS(6), .MSG_NIBBLES(8), .TICK_DIV(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    hex_scroll_ctrl #(.NUM_DIGITS(6), .MSG_NIBBLES(8), .TICK_DIV(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Window after k steps: HEX(i) shows message nibble k-1-i (0 = first).
    function automatic exp_t snap(input int c, input logic [31:0] m, input int k,
                                  input logic busy, input logic done);
        exp_t e;
        int   j;
        e.cyc  = c;
        e.busy = busy;
        e.done = done;
        e.dig  = '0;
        e.blk  = '1;
        for (int i = 0; i < 6; i++) begin
            j = k - 1 - i;
            if (j >= 0 && j < 8) begin
                e.dig[4*i +: 4] = m[31-4*j -: 4];
                e.blk[i]        = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic push(input bit sel, input exp_t e);
        if (sel) q1.push_back(e);
        else     q4.push_back(e);
    endtask

    // stop_off < 0: run to completion; otherwise the scroll is aborted on
    // edge a+stop_off and any step due on that edge never appears.
    task automatic push_run(input bit sel, input int a, input int div,
                            input logic [31:0] m, input int stop_off);
        push(sel, snap(a, m, 0, 1'b1, 1'b0));
        for (int k = 1; k <= 14; k++) begin
            if (stop_off >= 0 && div*k >= stop_off) break;
            if (k == 14) push(sel, snap(a + div*k, m, 14, 1'b0, 1'b1));
            else         push(sel, snap(a + div*k, m, k, 1'b1, 1'b0));
        end
        if (stop_off >= 0) push(sel, snap(a + stop_off, m, 14, 1'b0, 1'b0));
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [23:0] dig,
                           input logic [5:0] blk, input logic busy, input logic done,
                           input logic ready);
        chk({tag, "_cycle"}, cyc, e.cyc);
        chk({tag, "_digit"}, dig, e.dig);
        chk({tag, "_blank"}, blk, e.blk);
        chk({tag, "_busy"},  busy, e.busy);
        chk({tag, "_done"},  done, e.done);
        chk({tag, "_ready"}, ready, !e.busy);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cur4 = {bus4.digit, bus4.blank, bus4.busy, bus4.done};
            if (cur4 !== prev4) begin
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL div4_unexpected actual=%h required=no change at cycle %0d", cur4, cyc);
                end else begin
                    e4 = q4.pop_front();
                    compare("div4", e4, bus4.digit, bus4.blank, bus4.busy, bus4.done, bus4.msg_ready);
                end
            end
            prev4 = cur4;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            cur1 = {bus1.digit, bus1.blank, bus1.busy, bus1.done};
            if (cur1 !== prev1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL div1_unexpected actual=%h required=no change at cycle %0d", cur1, cyc);
                end else begin
                    e1 = q1.pop_front();
                    compare("div1", e1, bus1.digit, bus1.blank, bus1.busy, bus1.done, bus1.msg_ready);
                end
            end
            prev1 = cur1;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v, input logic [31:0] m);
        if (sel) begin
            bus1.msg_valid = v;
            bus1.msg_data  = m;
        end else begin
            bus4.msg_valid = v;
            bus4.msg_data  = m;
        end
    endtask

    task automatic run_full(input bit sel, input int div, input logic [31:0] m);
        int a;
        @(negedge clk);
        a = cyc + 1;
        drive(sel, 1'b1, m);
        push_run(sel, a, div, m, -1);
        push(sel, snap(a + 14*div + 1, m, 14, 1'b0, 1'b0));
        @(negedge clk);
        drive(sel, 1'b0, '0);
        wait_until(a + 14*div + 4);
    endtask

    task automatic run_abort(input bit sel, input int div, input logic [31:0] m,
                             input int off, input bit use_reset);
        int a;
        @(negedge clk);
        a = cyc + 1;
        drive(sel, 1'b1, m);
        push_run(sel, a, div, m, off);
        @(negedge clk);
        drive(sel, 1'b0, '0);
        wait_until(a + off - 1);
        if (use_reset)  reset     = 1'b1;
        else if (sel)   bus1.stop = 1'b1;
        else            bus4.stop = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus1.stop = 1'b0;
        bus4.stop = 1'b0;
        wait_until(a + off + 12);
    endtask

    initial begin
        int a;
        int b;
        bus4.msg_valid = 1'b0;
        bus4.msg_data  = '0;
        bus4.stop      = 1'b0;
        bus1.msg_valid = 1'b0;
        bus1.msg_data  = '0;
        bus1.stop      = 1'b0;
        reset          = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_blank4", bus4.blank, 6'h3F);
        chk("rst_digit4", bus4.digit, 24'h0);
        chk("rst_ready4", bus4.msg_ready, 1'b1);
        chk("rst_busy4",  bus4.busy, 1'b0);
        chk("rst_done4",  bus4.done, 1'b0);
        chk("rst_blank1", bus1.blank, 6'h3F);
        chk("rst_digit1", bus1.digit, 24'h0);
        chk("rst_ready1", bus1.msg_ready, 1'b1);
        chk("rst_busy1",  bus1.busy, 1'b0);
        chk("rst_done1",  bus1.done, 1'b0);
        prev4  = {bus4.digit, bus4.blank, bus4.busy, bus4.done};
        prev1  = {bus1.digit, bus1.blank, bus1.busy, bus1.done};
        mon_en = 1'b1;
        reset  = 1'b0;

        // Full scroll of the reference message.
        run_full(1'b0, 4, 32'h1234ABCD);

        // stop between steps, then stop on the same edge as a step.
        run_abort(1'b0, 4, 32'h1234ABCD, 10, 1'b0);
        run_abort(1'b0, 4, 32'h1234ABCD, 8, 1'b0);

        // stop while idle does nothing.
        @(negedge clk);
        bus4.stop = 1'b1;
        repeat (3) @(negedge clk);
        bus4.stop = 1'b0;

        // msg_valid during SCROLL ignored; new message accepted in the done cycle.
        @(negedge clk);
        a = cyc + 1;
        drive(1'b0, 1'b1, 32'h1234ABCD);
        push_run(1'b0, a, 4, 32'h1234ABCD, -1);
        @(negedge clk);
        drive(1'b0, 1'b0, '0);
        wait_until(a + 5);
        drive(1'b0, 1'b1, 32'hFFFFFFFF);
        wait_until(a + 30);
        drive(1'b0, 1'b0, '0);
        wait_until(a + 56);
        b = a + 57;
        drive(1'b0, 1'b1, 32'h98765432);
        push_run(1'b0, b, 4, 32'h98765432, -1);
        push(1'b0, snap(b + 57, 32'h98765432, 14, 1'b0, 1'b0));
        @(negedge clk);
        drive(1'b0, 1'b0, '0);
        wait_until(b + 60);

        // Reset mid-scroll, then a fresh message scrolls normally.
        run_abort(1'b0, 4, 32'h1234ABCD, 20, 1'b1);
        run_full(1'b0, 4, 32'h0F1E2D3C);

        // One step per clock.
        run_full(1'b1, 1, 32'h1234ABCD);
        run_abort(1'b1, 1, 32'hA5C3E1F0, 5, 1'b0);

        repeat (5) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
